// File: rtl/clint_timer.sv
// clint_timer: memory-mapped 64-bit machine timer with prescaler, compare register and level interrupt.
module clint_timer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  hit_o,
  output logic                  irq_o
);
  logic [63:0] mtime, mtimecmp;
  logic [7:0]  presc, presc_cnt;
  logic        en, irq, tick, wr;
  logic        wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic [2:0]  off;
  logic        unused_addr;
  assign unused_addr = ^addr_i[1:0];
  assign hit_o      = ce_i && addr_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
  assign off        = addr_i[4:2];
  assign wr         = hit_o && we_i;
  assign wr_time_lo = wr && off == 3'd0;
  assign wr_time_hi = wr && off == 3'd1;
  assign wr_cmp_lo  = wr && off == 3'd2;
  assign wr_cmp_hi  = wr && off == 3'd3;
  assign wr_ctrl    = wr && off == 3'd4;
  assign tick       = en && presc_cnt == presc;
  assign irq_o      = irq;
  // A ctrl write still ticks with the old settings; an mtime write suppresses the tick.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b1;
      presc     <= '0;
      presc_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_time_lo) mtime <= {mtime[63:32], wdata_i};
      else if (wr_time_hi) mtime <= {wdata_i, mtime[31:0]};
      else if (tick) mtime <= mtime + 64'd1;
      presc_cnt <= (wr_time_lo || wr_time_hi || wr_ctrl || tick) ? 8'd0 :
                   en ? presc_cnt + 8'd1 : presc_cnt;
      if (wr_cmp_lo) mtimecmp[31:0] <= wdata_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata_i;
      if (wr_ctrl) begin
        en    <= wdata_i[0];
        presc <= wdata_i[15:8];
      end
      irq <= mtime >= mtimecmp;
    end
  end
  always_comb begin
    rdata_o = !hit_o      ? '0 :
              off == 3'd0 ? mtime[31:0] :
              off == 3'd1 ? mtime[63:32] :
              off == 3'd2 ? mtimecmp[31:0] :
              off == 3'd3 ? mtimecmp[63:32] :
              off == 3'd4 ? {16'd0, presc, 7'd0, en} :
              off == 3'd5 ? {31'd0, irq} : '0;
  end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed checks of the timer register map, prescaler, carry, interrupt and decode.
module tb_clint_timer;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic        clk = 1'b0, rst_n = 1'b1, ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        hit, irq;
  int          checks = 0, errors = 0;

  clint_timer dut (
    .clk_i(clk), .rst_i(rst_n), .ce_i(ce), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .hit_o(hit), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] o, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = BASE | {27'd0, o};
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] o, input logic [31:0] exp);
    logic [31:0] d;
    rd(o, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = BASE | {27'd0, o}; wdata = d;
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    ce = 1'b1; addr = BASE;
    #1;
    chk("rst_hit", {31'd0, hit}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rdchk("rst_time_lo", 5'h00, 32'd0);
    rdchk("rst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rdchk("rst_ctrl", 5'h10, 32'h0000_0001);
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("run0", 5'h00, 32'd0);
    step();
    rdchk("run1", 5'h00, 32'd1);
    chk("run1_irq", {31'd0, irq}, 32'd0);
    step();
    rdchk("run2", 5'h00, 32'd2);
    chk("run2_irq", {31'd0, irq}, 32'd0);

    wr(5'h10, 32'h0000_0301);
    rdchk("ctrl_rb", 5'h10, 32'h0000_0301);
    wr(5'h00, 32'd100);
    rdchk("presc_t0", 5'h00, 32'd100);
    step(3);
    rdchk("presc_t3", 5'h00, 32'd100);
    step();
    rdchk("presc_t4", 5'h00, 32'd101);
    step(4);
    rdchk("presc_t8", 5'h00, 32'd102);
    wr(5'h10, 32'd0);
    rdchk("frz0", 5'h00, 32'd102);
    step(20);
    rdchk("frz20", 5'h00, 32'd102);

    wr(5'h10, 32'h0000_0001);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'd0);
    rdchk("carry_lo0", 5'h00, 32'hFFFF_FFFE);
    rdchk("carry_hi0", 5'h04, 32'd0);
    step(2);
    rdchk("carry_lo", 5'h00, 32'd0);
    rdchk("carry_hi", 5'h04, 32'd1);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    rdchk("max_lo", 5'h00, 32'hFFFF_FFFF);
    rdchk("max_hi", 5'h04, 32'hFFFF_FFFF);
    step();
    rdchk("wrap_lo", 5'h00, 32'd0);
    rdchk("wrap_hi", 5'h04, 32'd0);

    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    rdchk("cmp_lo_rb", 5'h08, 32'd10);
    wr(5'h00, 32'd0);
    step(9);
    chk("irq_pre9", {31'd0, irq}, 32'd0);
    step();
    rdchk("irq_t10", 5'h00, 32'd10);
    chk("irq_pre10", {31'd0, irq}, 32'd0);
    step();
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rdchk("status1", 5'h14, 32'd1);
    wr(5'h0C, 32'd1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("irq_fall", {31'd0, irq}, 32'd0);

    wr(5'h00, 32'h1234_5678);
    rdchk("tick_wr", 5'h00, 32'h1234_5678);
    step();
    rdchk("tick_wr_next", 5'h00, 32'h1234_5679);

    wr(5'h00, 32'h0000_0100);
    ce = 1'b1; we = 1'b1; addr = 32'h0300_0000; wdata = 32'h0000_DEAD;
    #1;
    chk("out_hit", {31'd0, hit}, 32'd0);
    chk("out_rdata", rdata, 32'd0);
    step();
    ce = 1'b0; we = 1'b0;
    rdchk("out_nowr", 5'h00, 32'h0000_0101);
    addr = BASE;
    #1;
    chk("noce_hit", {31'd0, hit}, 32'd0);
    chk("noce_rdata", rdata, 32'd0);

    wr(5'h18, 32'h0000_0055);
    rdchk("rsv18", 5'h18, 32'd0);
    wr(5'h14, 32'hFFFF_FFFF);
    rdchk("status_ro", 5'h14, 32'd0);
    wr(5'h1C, 32'h0000_0001);
    rdchk("rsv1c", 5'h1C, 32'd0);
    rdchk("rsv_time_hi", 5'h04, 32'd0);
    rdchk("rsv_cmp_hi", 5'h0C, 32'd1);
    rdchk("rsv_cmp_lo", 5'h08, 32'd10);
    wr(5'h10, 32'hFFFF_FFFF);
    rdchk("ctrl_mask", 5'h10, 32'h0000_FF01);

    wr(5'h0C, 32'd0);
    step();
    chk("irq_again", {31'd0, irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    rdchk("async_time", 5'h00, 32'd0);
    rdchk("async_cmp", 5'h08, 32'hFFFF_FFFF);
    rdchk("async_ctrl", 5'h10, 32'h0000_0001);
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
